uart_rx_packet_ctrl: RTL and testbench

UART_RX_PACKET_CTRL -- requirements
Module: uart_rx_packet_ctrl

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_timeout.sv | 25 ++
 rtl/uart_rx_packet_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding, error causes,
// default start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DELIVER
  } state_e;

  localparam logic [1:0] ERR_OVERRUN  = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYC-1.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + W'(1);
  end

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Framed packet receiver: SYNC, LEN, payload, checksum (length + payload, mod 256),
// then hands the buffered payload to a valid/ready consumer.
module uart_rx_packet_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [4:0] pkt_len,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [4:0] len_q, len_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       wr_en;
  logic [7:0] mem_q [MAX_LEN];
  logic       to_clr, to_en, to_exp;
  logic       last_idx, xfer;

  assign last_idx = (idx_q == 4'(len_q - 5'd1));
  assign xfer     = pkt_valid && pkt_ready;
  assign to_clr   = rx_done || (state_d != state_q);
  assign to_en    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  uart_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expire_o (to_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    len_d   = len_q;
    err_d   = 1'b0;
    code_d  = ERR_OVERRUN;
    wr_en   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (rx_done && rx_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_done) begin
          if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
            len_d   = rx_data[4:0];
            sum_d   = rx_data;
            idx_d   = 4'd0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = ST_SYNC;
          end
        end else if (to_exp) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_SYNC;
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data;
          if (last_idx) begin
            idx_d   = 4'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (to_exp) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_SYNC;
        end
      end
      ST_CHECK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            state_d = ST_DELIVER;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = ST_SYNC;
          end
        end else if (to_exp) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_SYNC;
        end
      end
      ST_DELIVER: begin
        // A byte arriving mid-delivery is dropped; the read side is untouched.
        if (rx_done) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (xfer) begin
          if (last_idx) begin
            idx_d   = 4'd0;
            state_d = ST_SYNC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      idx_q   <= 4'd0;
      sum_q   <= 8'd0;
      len_q   <= 5'd0;
      err_q   <= 1'b0;
      code_q  <= ERR_OVERRUN;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Payload storage carries no reset; stale bytes are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q] <= rx_data;
  end

  assign pkt_valid = (state_q == ST_DELIVER);
  assign pkt_last  = pkt_valid && last_idx;
  assign pkt_data  = pkt_valid ? mem_q[idx_q] : 8'd0;
  assign pkt_len   = len_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign busy      = (state_q != ST_SYNC);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl; checksum = (len + payload) mod 256.
module tb_uart_rx_packet_ctrl;

  localparam int unsigned TC = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready = 1'b1;
  logic       pkt_last;
  logic [4:0] pkt_len;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_packet_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_last  (pkt_last),
    .pkt_len   (pkt_len),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    chk("rst_valid", pkt_valid, 0);
    chk("rst_last", pkt_last, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_len", pkt_len, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // A: 3-byte packet, consumer always ready; 03+11+22+33 = 69
    pkt_ready = 1'b1;
    send(8'h5C);
    chk("A_junk_busy", busy, 0);
    send(8'hA5);
    chk("A_busy", busy, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("A_prevalid", pkt_valid, 0);
    send(8'h69);
    chk("A_err", err, 0);
    chk("A_v0", pkt_valid, 1); chk("A_d0", pkt_data, 8'h11); chk("A_l0", pkt_last, 0);
    chk("A_len", pkt_len, 3);
    tick();
    chk("A_d1", pkt_data, 8'h22); chk("A_l1", pkt_last, 0);
    tick();
    chk("A_v2", pkt_valid, 1); chk("A_d2", pkt_data, 8'h33); chk("A_l2", pkt_last, 1);
    tick();
    chk("A_done_valid", pkt_valid, 0);
    chk("A_done_busy", busy, 0);

    // B: checksum mismatch
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    chk("B_err", err, 1); chk("B_code", err_code, 2);
    chk("B_valid", pkt_valid, 0); chk("B_busy", busy, 0);
    tick();
    chk("B_pulse", err, 0);
    chk("B_valid2", pkt_valid, 0);

    // C: zero and oversize length
    send(8'hA5); send(8'h00);
    chk("C0_err", err, 1); chk("C0_code", err_code, 1); chk("C0_busy", busy, 0);
    tick();
    chk("C0_pulse", err, 0);
    send(8'hA5); send(8'h11);
    chk("C1_err", err, 1); chk("C1_code", err_code, 1);
    tick();

    // D: timeout mid-payload, then a clean packet (02+AB+CD = 17A -> 7A)
    send(8'hA5); send(8'h04); send(8'h01);
    n = 0;
    while (!err && n < TC + 10) begin
      tick();
      n++;
    end
    chk("D_err", err, 1);
    chk("D_wait", n, TC);
    chk("D_code", err_code, 3);
    chk("D_busy", busy, 0);
    tick();
    send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
    chk("D_err2", err, 0);
    chk("D_d0", pkt_data, 8'hAB); chk("D_l0", pkt_last, 0);
    tick();
    chk("D_d1", pkt_data, 8'hCD); chk("D_l1", pkt_last, 1);
    tick();
    chk("D_done", pkt_valid, 0);

    // E: stalled delivery with a byte injected (02+5A+C3 = 11F -> 1F)
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hC3);
    pkt_ready = 1'b0;
    send(8'h1F);
    chk("E_v0", pkt_valid, 1); chk("E_d0", pkt_data, 8'h5A);
    send(8'hEE);
    chk("E_ovr_err", err, 1); chk("E_ovr_code", err_code, 0);
    chk("E_hold_d0", pkt_data, 8'h5A); chk("E_hold_l0", pkt_last, 0);
    pkt_ready = 1'b1;
    tick();
    chk("E_d1", pkt_data, 8'hC3); chk("E_l1", pkt_last, 1);
    chk("E_err_clr", err, 0);
    pkt_ready = 1'b0;
    tick();
    chk("E_hold_d1", pkt_data, 8'hC3); chk("E_hold_v1", pkt_valid, 1);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b1;
    chk("E_done_valid", pkt_valid, 0);
    chk("E_done_busy", busy, 0);

    // F: asynchronous reset mid-payload, then 01+7F = 80
    send(8'hA5); send(8'h03); send(8'h01);
    chk("F_pre_busy", busy, 1);
    chk("F_pre_len", pkt_len, 3);
    rst_n = 1'b0;
    #1;
    chk("F_rst_busy", busy, 0);
    chk("F_rst_len", pkt_len, 0);
    chk("F_rst_valid", pkt_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    chk("F_err", err, 0);
    chk("F_v", pkt_valid, 1); chk("F_d", pkt_data, 8'h7F);
    chk("F_l", pkt_last, 1); chk("F_len", pkt_len, 1);
    tick();
    chk("F_done", pkt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
